// File: rtl/if_fetch_ctrl_pkg.sv
// Shared definitions for the IF fetch sequencer: state encoding and control bundles.
package if_fetch_ctrl_pkg;

    // State encoding is also used by the hazard unit and debug logic.
    typedef enum logic [1:0] {
        IFC_BOOT = 2'd0,
        IFC_RUN  = 2'd1,
        IFC_PEND = 2'd2
    } ifc_state_e;

    // IF/ID bubble contents: the register loads all zeros on a flush.
    localparam logic IFID_BUBBLE_BIT = 1'b0;

    // Per-cycle fetch control bundle driven by the FSM decode.
    typedef struct packed {
        logic pc_we;
        logic mux_sel;
        logic ifid_we;
        logic ifid_flush;
    } ifc_ctrl_t;

    localparam ifc_ctrl_t CTRL_BOOT  = '{pc_we: 1'b0, mux_sel: 1'b0, ifid_we: 1'b1, ifid_flush: 1'b1};
    localparam ifc_ctrl_t CTRL_FETCH = '{pc_we: 1'b1, mux_sel: 1'b0, ifid_we: 1'b1, ifid_flush: 1'b0};
    localparam ifc_ctrl_t CTRL_HOLD  = '{pc_we: 1'b0, mux_sel: 1'b0, ifid_we: 1'b0, ifid_flush: 1'b0};
    localparam ifc_ctrl_t CTRL_REDIR = '{pc_we: 1'b1, mux_sel: 1'b1, ifid_we: 1'b1, ifid_flush: 1'b1};

endpackage

// File: rtl/if_fetch_ctrl_boot_counter.sv
// Boot-window counter: counts enabled cycles and flags the last one.
module if_fetch_ctrl_boot_counter #(
    parameter int TC = 2
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_clr,
    input  logic i_en,
    output logic o_done
);
    localparam int CW = $clog2(TC) + 1;
    localparam logic [CW-1:0] LAST = CW'(TC - 1);

    logic [CW-1:0] cnt_q;

    // Done is a combinational pulse during the final counted cycle.
    assign o_done = i_en && (cnt_q == LAST);

    // Count while enabled; clear whenever the window is not active.
    always_ff @(posedge i_clk) begin
        if (i_rst || i_clr) cnt_q <= '0;
        else if (i_en)      cnt_q <= cnt_q + 1'b1;
    end

endmodule

// File: rtl/if_fetch_ctrl.sv
// Instruction-fetch sequencer: boot hold, stall freeze and deferred branch redirect.
module if_fetch_ctrl
    import if_fetch_ctrl_pkg::*;
#(
    parameter int PC_SIZE     = 32,
    parameter int BOOT_CYCLES = 2
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_stall,
    input  logic               i_redirect,
    input  logic [PC_SIZE-1:0] i_redirect_pc,
    output logic               o_pc_we,
    output logic               o_mux_if_sel,
    output logic [PC_SIZE-1:0] o_redirect_pc,
    output logic               o_ifid_we,
    output logic               o_ifid_flush,
    output logic               o_ifid_valid,
    output logic [1:0]         o_state
);
    ifc_state_e         state_q, state_d;
    ifc_ctrl_t          ctrl;
    logic [PC_SIZE-1:0] tgt_q;
    logic               tgt_we;
    logic               boot_redir_q;
    logic               boot_done;
    logic               in_boot;

    assign in_boot = (state_q == IFC_BOOT);

    if_fetch_ctrl_boot_counter #(.TC(BOOT_CYCLES)) u_boot_cnt (
        .i_clk  (i_clk),
        .i_rst  (i_rst),
        .i_clr  (!in_boot),
        .i_en   (in_boot),
        .o_done (boot_done)
    );

    // Next-state and control decode; a live redirect always beats the latched target.
    always_comb begin
        state_d = state_q;
        ctrl    = CTRL_HOLD;
        tgt_we  = 1'b0;
        case (state_q)
            IFC_BOOT: begin
                ctrl   = CTRL_BOOT;
                tgt_we = i_redirect;
                if (boot_done)
                    state_d = (boot_redir_q || i_redirect) ? IFC_PEND : IFC_RUN;
            end
            IFC_RUN: begin
                if (i_stall) begin
                    ctrl = CTRL_HOLD;
                    if (i_redirect) begin
                        tgt_we  = 1'b1;
                        state_d = IFC_PEND;
                    end
                end else if (i_redirect) begin
                    ctrl = CTRL_REDIR;
                end else begin
                    ctrl = CTRL_FETCH;
                end
            end
            IFC_PEND: begin
                if (i_stall) begin
                    ctrl   = CTRL_HOLD;
                    tgt_we = i_redirect;
                end else begin
                    ctrl    = CTRL_REDIR;
                    state_d = IFC_RUN;
                end
            end
            default: begin
                // Unused encoding: behave as BOOT and recover there.
                ctrl    = CTRL_BOOT;
                state_d = IFC_BOOT;
            end
        endcase
    end

    assign o_pc_we       = ctrl.pc_we;
    assign o_mux_if_sel  = ctrl.mux_sel;
    assign o_ifid_we     = ctrl.ifid_we;
    assign o_ifid_flush  = ctrl.ifid_flush;
    assign o_state       = state_q;
    assign o_redirect_pc = ((state_q == IFC_PEND || in_boot) && !i_redirect) ? tgt_q : i_redirect_pc;

    // State register.
    always_ff @(posedge i_clk) begin
        if (i_rst) state_q <= IFC_BOOT;
        else       state_q <= state_d;
    end

    // Pending redirect target; newest redirect overwrites.
    always_ff @(posedge i_clk) begin
        if (i_rst)       tgt_q <= '0;
        else if (tgt_we) tgt_q <= i_redirect_pc;
    end

    // Remembers that a redirect arrived while booting.
    always_ff @(posedge i_clk) begin
        if (i_rst || !in_boot) boot_redir_q <= 1'b0;
        else if (i_redirect)   boot_redir_q <= 1'b1;
    end

    // IF/ID valid: a flush loads the bubble, a normal load marks valid.
    always_ff @(posedge i_clk) begin
        if (i_rst)          o_ifid_valid <= IFID_BUBBLE_BIT;
        else if (ctrl.ifid_we) o_ifid_valid <= !ctrl.ifid_flush;
    end

endmodule

// File: tb/tb_if_fetch_ctrl.sv
// Scoreboard bench for if_fetch_ctrl: directed plan followed by random traffic.
module tb_if_fetch_ctrl;
    localparam int PC_SIZE     = 32;
    localparam int BOOT_CYCLES = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stall = 1'b0;
    logic        redir = 1'b0;
    logic [31:0] redir_pc = '0;
    logic        pc_we, mux_sel, ifid_we, ifid_flush, ifid_valid;
    logic [31:0] rpc;
    logic [1:0]  st;

    if_fetch_ctrl #(.PC_SIZE(PC_SIZE), .BOOT_CYCLES(BOOT_CYCLES)) dut (
        .i_clk         (clk),
        .i_rst         (rst),
        .i_stall       (stall),
        .i_redirect    (redir),
        .i_redirect_pc (redir_pc),
        .o_pc_we       (pc_we),
        .o_mux_if_sel  (mux_sel),
        .o_redirect_pc (rpc),
        .o_ifid_we     (ifid_we),
        .o_ifid_flush  (ifid_flush),
        .o_ifid_valid  (ifid_valid),
        .o_state       (st)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          chk_flush;
        bit          chk_mux;
        bit          pc_we;
        bit          ifid_we;
        bit          flush;
        bit          mux;
        logic [31:0] rpc;
        logic [1:0]  st;
        bit          valid;
    } exp_t;

    exp_t q[$];
    int   errors = 0;
    int   checks = 0;

    // Reference model: boot countdown, pending-target flag, valid bit.
    bit          m_known = 0;
    bit          m_boot;
    int          m_left;
    bit          m_pend;
    logic [31:0] m_tgt;
    bit          m_valid;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock of stimulus: drive inputs, push expected outputs, advance the model.
    task automatic step(input bit r, input bit s, input bit d, input logic [31:0] pc);
        exp_t e;
        @(posedge clk);
        #1;
        rst = r; stall = s; redir = d; redir_pc = pc;
        if (m_known) begin
            e.st        = m_boot ? 2'd0 : (m_pend ? 2'd2 : 2'd1);
            e.valid     = m_valid;
            e.rpc       = ((m_boot || m_pend) && !d) ? m_tgt : pc;
            e.chk_flush = 0; e.chk_mux = 0; e.flush = 0; e.mux = 0;
            if (m_boot) begin
                e.pc_we = 0; e.ifid_we = 1; e.flush = 1; e.chk_flush = 1; e.mux = 0; e.chk_mux = 1;
            end else if (s) begin
                e.pc_we = 0; e.ifid_we = 0;
            end else if (d || m_pend) begin
                e.pc_we = 1; e.ifid_we = 1; e.flush = 1; e.chk_flush = 1; e.mux = 1; e.chk_mux = 1;
            end else begin
                e.pc_we = 1; e.ifid_we = 1; e.flush = 0; e.chk_flush = 1; e.mux = 0; e.chk_mux = 1;
            end
            q.push_back(e);
        end
        if (r) begin
            m_known = 1; m_boot = 1; m_left = BOOT_CYCLES; m_pend = 0; m_tgt = '0; m_valid = 0;
        end else if (m_known) begin
            if (m_boot) begin
                if (d) begin m_tgt = pc; m_pend = 1; end
                m_valid = 0;
                m_left--;
                if (m_left == 0) m_boot = 0;
            end else if (s) begin
                if (d) begin m_tgt = pc; m_pend = 1; end
            end else if (d || m_pend) begin
                m_valid = 0; m_pend = 0;
            end else begin
                m_valid = 1;
            end
        end
    endtask

    // Monitor: compare DUT outputs against the oldest expectation each cycle.
    always @(negedge clk) begin
        exp_t e;
        if (q.size() > 0) begin
            e = q.pop_front();
            chk("state", {30'd0, st}, {30'd0, e.st});
            chk("ifid_valid", {31'd0, ifid_valid}, {31'd0, e.valid});
            chk("pc_we", {31'd0, pc_we}, {31'd0, e.pc_we});
            chk("ifid_we", {31'd0, ifid_we}, {31'd0, e.ifid_we});
            chk("redirect_pc", rpc, e.rpc);
            if (e.chk_flush) chk("ifid_flush", {31'd0, ifid_flush}, {31'd0, e.flush});
            if (e.chk_mux)   chk("mux_sel", {31'd0, mux_sel}, {31'd0, e.mux});
        end
    end

    initial begin
        // Reset, boot window, first fetches.
        step(1, 0, 0, 0);
        step(0, 0, 0, 0);
        step(0, 1, 0, 0);            // stall ignored in BOOT
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);
        // Redirect in RUN.
        step(0, 0, 1, 32'h100);
        step(0, 0, 0, 0);
        // Stall held 3 cycles.
        step(0, 1, 0, 0);
        step(0, 1, 0, 0);
        step(0, 1, 0, 0);
        step(0, 0, 0, 0);
        // Stall with redirect, newer redirect while stalled, release.
        step(0, 1, 1, 32'h200);
        step(0, 1, 0, 32'h5);
        step(0, 1, 1, 32'h300);
        step(0, 1, 0, 32'h7);
        step(0, 0, 0, 32'h9);
        step(0, 0, 0, 0);
        // Redirect during boot becomes pending.
        step(1, 0, 0, 0);
        step(0, 0, 1, 32'h40);
        step(0, 0, 0, 32'h44);
        step(0, 0, 0, 32'h48);
        step(0, 0, 0, 0);
        // Reset while PEND discards the target.
        step(0, 1, 1, 32'h300);
        step(0, 1, 0, 0);
        step(1, 1, 0, 0);
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);
        // Random traffic.
        for (int i = 0; i < 600; i++) begin
            step(($urandom_range(63) == 0), ($urandom_range(2) == 0),
                 ($urandom_range(3) == 0), $urandom);
        end
        @(posedge clk);
        #1;
        rst = 0; stall = 0; redir = 0;
        @(negedge clk);
        #1;
        chk("scoreboard_drained", q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
